stream_demux_1xn: RTL and testbench

//  Packet-aware 1-to-N stream demultiplexer, the splitting counterpart of the mux_2x1 selection logic.
//  - Accepts one valid/ready input stream.
//  - Routes each whole packet to the output channel chosen by s_sel on the packet's first beat.
//  - Has a single registered output stage and sits between a shared producer and N consumers.

---
 rtl/demux_pkg.sv | 20 ++
 rtl/stream_reg_slice.sv | 46 ++++
 rtl/stream_demux_1xn.sv | 150 +++++++++++++++
 tb/tb_stream_demux_1xn.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants for the packet-aware stream demultiplexer.
//                It holds the FSM state encoding and the default data
//                width and channel count.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;  // waiting for the first beat of a packet
  localparam logic [1:0] ST_ROUTE = 2'd1;  // locked to cur_sel until the last beat
  localparam logic [1:0] ST_DROP  = 2'd2;  // discarding a packet with an invalid select

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 4;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/stream_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module      : stream_reg_slice
//  Description : Single-entry valid/ready register stage. It runs at full
//                throughput, because a new beat can load in the same cycle
//                that the held beat drains.
//  Ports       : clk, rst_n                      clock / async active-low reset
//                in_valid_i, in_ready_o, in_data_i     upstream handshake
//                out_valid_o, out_ready_i, out_data_o  downstream handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_reg_slice #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Data is only written on a load, so the beat stays stable while it waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule : stream_reg_slice
`default_nettype wire

// File: rtl/stream_demux_1xn.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux_1xn
//  Description : Packet-aware 1-to-N stream demultiplexer. The first beat of
//                each packet chooses the output channel through s_sel. The
//                whole packet then goes to that channel through one shared
//                output register. A packet whose select is out of range is
//                dropped, and a saturating counter records each drop.
//  Ports       : clk, rst_n                 clock / async active-low reset
//                s_valid/s_ready/s_data/s_last/s_sel   input stream
//                m_valid[N]/m_ready[N]      per-channel handshake
//                m_data/m_last              shared output beat
//                drop_cnt                   dropped-packet counter
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1xn
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic [SEL_W-1:0] s_sel,
  output logic [N-1:0]     m_valid,
  input  logic [N-1:0]     m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] drop_cnt
);

  // One extra bit so that N itself can be represented for the range check.
  localparam logic [SEL_W:0] C_N = (SEL_W+1)'(N);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0] drop_cnt_q;

  logic             w_sel_ok;
  logic             w_slice_in_ready;
  logic             w_slice_out_valid;
  logic [WIDTH:0]   w_slice_out_data;
  logic             w_held_ready;
  logic             w_ready_raw;
  logic             w_load;
  logic             w_drop_inc;
  logic             w_accept;

  assign w_sel_ok     = ({1'b0, s_sel} < C_N);
  assign w_held_ready = m_ready[cur_sel_q];
  // Hold off the producer while reset is asserted.
  assign s_ready      = rst_n && w_ready_raw;
  assign w_accept     = s_valid && s_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_sel_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      if (w_drop_inc && (drop_cnt_q != {CNT_W{1'b1}})) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept && !s_last) begin
          state_d = w_sel_ok ? ST_ROUTE : ST_DROP;
        end
      end
      ST_ROUTE, ST_DROP: begin
        if (w_accept && s_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ state outputs
  // In IDLE, an out-of-range first beat still waits on the held beat. This
  // keeps the drop in stream order with the beats routed before it.
  // cur_sel only changes together with the beat it belongs to. The held beat
  // therefore drains on its own channel even when the next packet is loaded
  // in the same cycle.
  always_comb begin
    w_ready_raw = 1'b0;
    w_load      = 1'b0;
    w_drop_inc  = 1'b0;
    cur_sel_d   = cur_sel_q;
    case (state_q)
      ST_DROP: begin
        w_ready_raw = 1'b1;
      end
      ST_ROUTE: begin
        w_ready_raw = w_slice_in_ready;
        w_load      = w_accept;
      end
      default: begin
        w_ready_raw = w_slice_in_ready;
        if (w_accept) begin
          if (w_sel_ok) begin
            w_load    = 1'b1;
            cur_sel_d = s_sel;
          end else begin
            w_drop_inc = 1'b1;
          end
        end
      end
    endcase
  end

  // ------------------------------------------------------------ output stage
  stream_reg_slice #(
    .W (WIDTH + 1)
  ) u_slice (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (w_load),
    .in_ready_o  (w_slice_in_ready),
    .in_data_i   ({s_last, s_data}),
    .out_valid_o (w_slice_out_valid),
    .out_ready_i (w_held_ready),
    .out_data_o  (w_slice_out_data)
  );

  assign m_last   = w_slice_out_data[WIDTH];
  assign m_data   = w_slice_out_data[WIDTH-1:0];
  assign drop_cnt = drop_cnt_q;

  for (genvar i = 0; i < N; i++) begin : g_onehot
    assign m_valid[i] = w_slice_out_valid && (cur_sel_q == SEL_W'(i));
  end

endmodule : stream_demux_1xn
`default_nettype wire

// File: tb/tb_stream_demux_1xn.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_demux_1xn
//  Description : Directed self-checking bench for stream_demux_1xn. Instance
//                A uses the default N=4. Instance B uses N=3 with a 2-bit
//                drop counter, so it can exercise invalid selects and
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1xn;

  logic       clk = 1'b0;
  logic       rst_n;

  // instance A: N=4
  logic       s_valid, s_ready, s_last, m_last;
  logic [7:0] s_data, m_data;
  logic [1:0] s_sel;
  logic [3:0] m_valid, m_ready;
  logic [15:0] drop_cnt;

  // instance B: N=3, CNT_W=2
  logic       b_s_valid, b_s_ready, b_s_last, b_m_last;
  logic [7:0] b_s_data, b_m_data;
  logic [1:0] b_s_sel;
  logic [2:0] b_m_valid, b_m_ready;
  logic [1:0] b_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_demux_1xn #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .drop_cnt(drop_cnt)
  );

  stream_demux_1xn #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last), .s_sel(b_s_sel),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .drop_cnt(b_drop_cnt)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [7:0] d, input logic [1:0] sel, input logic last);
    s_valid = 1'b1; s_data = d; s_sel = sel; s_last = last;
  endtask

  task automatic beat_b(input logic [7:0] d, input logic [1:0] sel, input logic last);
    b_s_valid = 1'b1; b_s_data = d; b_s_sel = sel; b_s_last = last;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_sel = 2'd0; m_ready = 4'b0000;
    b_s_valid = 1'b0; b_s_data = 8'h00; b_s_last = 1'b0; b_s_sel = 2'd0; b_m_ready = 3'b000;
    #3;
    s_valid = 1'b1;  // s_ready must stay low while reset is asserted
    #1;
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    n_tests++; if (m_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0000", m_valid); end
    n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    n_tests++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    n_tests++; if (b_drop_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_b_drop_cnt got=%0d exp=0", b_drop_cnt); end
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic();
    logic [7:0] d;
    m_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      d = 8'hA1 + 8'(i);
      beat_a(d, 2'd2, (i == 2));
      #1;
      n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_s_ready beat=%0d got=%b exp=1", i, s_ready); end
      tick();
      n_tests++; if (m_valid !== 4'b0100) begin n_fail++; $display("FAIL basic_m_valid beat=%0d got=%b exp=0100", i, m_valid); end
      n_tests++; if (m_data !== d) begin n_fail++; $display("FAIL basic_m_data beat=%0d got=%h exp=%h", i, m_data, d); end
      n_tests++; if (m_last !== (i == 2)) begin n_fail++; $display("FAIL basic_m_last beat=%0d got=%b exp=%b", i, m_last, (i == 2)); end
    end
    s_valid = 1'b0;
    tick();
    n_tests++; if (m_valid !== 4'b0000) begin n_fail++; $display("FAIL basic_drain got=%b exp=0000", m_valid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_sel_change();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hB1; exp_d[1] = 8'hB2; exp_d[2] = 8'hB3;
    m_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      beat_a(exp_d[i], (i == 0) ? 2'd1 : 2'd3, (i == 2));
      tick();
      n_tests++; if (m_valid !== 4'b0010) begin n_fail++; $display("FAIL selchg_m_valid beat=%0d got=%b exp=0010", i, m_valid); end
      n_tests++; if (m_data !== exp_d[i]) begin n_fail++; $display("FAIL selchg_m_data beat=%0d got=%h exp=%h", i, m_data, exp_d[i]); end
    end
    // After the last beat, a new packet takes its select again.
    beat_a(8'hB4, 2'd3, 1'b1);
    tick();
    n_tests++; if (m_valid !== 4'b1000) begin n_fail++; $display("FAIL selchg_next_pkt got=%b exp=1000", m_valid); end
    s_valid = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    m_ready = 4'b1111;
    beat_a(8'h10, 2'd0, 1'b0);
    tick();
    n_tests++; if (m_valid !== 4'b0001) begin n_fail++; $display("FAIL bp_first got=%b exp=0001", m_valid); end
    // Channel 0 stalls. The ready bits of the other channels are high and must be ignored.
    m_ready = 4'b1110;
    beat_a(8'h11, 2'd2, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready cyc=%0d got=%b exp=0", c, s_ready); end
      tick();
      n_tests++; if (m_data !== 8'h10 || m_valid !== 4'b0001) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=10/0001", c, m_data, m_valid);
      end
    end
    m_ready = 4'b1111;
    #1;
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", s_ready); end
    tick();
    n_tests++; if (m_data !== 8'h11 || m_valid !== 4'b0001 || m_last !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got=%h/%b/%b exp=11/0001/1", m_data, m_valid, m_last);
    end
    s_valid = 1'b0;
    tick();
    n_tests++; if (m_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_no_dup got=%b exp=0000", m_valid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    m_ready = 4'b1111;
    beat_a(8'h55, 2'd0, 1'b1);
    tick();
    n_tests++; if (m_valid !== 4'b0001 || m_data !== 8'h55) begin
      n_fail++; $display("FAIL b2b_first got=%b/%h exp=0001/55", m_valid, m_data);
    end
    beat_a(8'h66, 2'd3, 1'b1);
    #1;
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", s_ready); end
    tick();
    n_tests++; if (m_valid !== 4'b1000 || m_data !== 8'h66) begin
      n_fail++; $display("FAIL b2b_second got=%b/%h exp=1000/66", m_valid, m_data);
    end
    s_valid = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_drop();
    b_m_ready = 3'b111;
    beat_b(8'hC1, 2'd3, 1'b0);
    #1;
    n_tests++; if (b_s_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready got=%b exp=1", b_s_ready); end
    tick();
    n_tests++; if (b_m_valid !== 3'b000) begin n_fail++; $display("FAIL drop_m_valid1 got=%b exp=000", b_m_valid); end
    n_tests++; if (b_drop_cnt !== 2'd1) begin n_fail++; $display("FAIL drop_cnt1 got=%0d exp=1", b_drop_cnt); end
    beat_b(8'hC2, 2'd0, 1'b1);  // select ignored mid-packet
    tick();
    n_tests++; if (b_m_valid !== 3'b000 || b_drop_cnt !== 2'd1) begin
      n_fail++; $display("FAIL drop_tail got=%b/%0d exp=000/1", b_m_valid, b_drop_cnt);
    end
    beat_b(8'hC3, 2'd2, 1'b1);
    tick();
    n_tests++; if (b_m_valid !== 3'b100 || b_m_data !== 8'hC3) begin
      n_fail++; $display("FAIL drop_recover got=%b/%h exp=100/c3", b_m_valid, b_m_data);
    end
    for (int p = 0; p < 4; p++) begin
      beat_b(8'hD0, 2'd3, 1'b0);
      tick();
      beat_b(8'hD1, 2'd3, 1'b1);
      tick();
    end
    b_s_valid = 1'b0;
    tick();
    n_tests++; if (b_drop_cnt !== 2'd3) begin n_fail++; $display("FAIL drop_saturate got=%0d exp=3", b_drop_cnt); end
    n_tests++; if (b_m_valid !== 3'b000) begin n_fail++; $display("FAIL drop_no_valid got=%b exp=000", b_m_valid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    m_ready = 4'b1011;  // channel 2 stalled, so the beat stays held
    beat_a(8'hD1, 2'd2, 1'b0);
    tick();
    n_tests++; if (m_valid !== 4'b0100) begin n_fail++; $display("FAIL rstmid_held got=%b exp=0100", m_valid); end
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (m_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async got=%b exp=0000", m_valid); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_s_ready got=%b exp=0", s_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_tests++; if (m_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_after got=%b exp=0000", m_valid); end
    m_ready = 4'b1111;
    beat_a(8'hD2, 2'd1, 1'b1);
    tick();
    n_tests++; if (m_valid !== 4'b0010 || m_data !== 8'hD2) begin
      n_fail++; $display("FAIL rstmid_new_pkt got=%b/%h exp=0010/d2", m_valid, m_data);
    end
    s_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_change();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_stream_demux_1xn
`default_nettype wire
